// File: rtl/risk_sequencer.sv
// risk_sequencer: ID-stage hazard sequencer for the 5-stage MIPS core.
// Detects load-use / branch-operand hazards, drives the bubble mux select,
// gates PC and IF/ID writes, flushes IF/ID on taken transfers and drains
// the pipeline after HALT.
// Optional build macro: RISK_PERF_CNT_EN adds stall/flush performance counters.
module risk_sequencer #(
    parameter int DRAIN_CYCLES = 4,
    parameter int REG_W        = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_id_branch,
    input  logic             i_id_taken,
    input  logic             i_id_halt,
    input  logic             i_ex_reg_write,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_dst,
    output logic             o_risk,
    output logic             o_pc_write,
    output logic             o_if_id_write,
    output logic             o_if_id_flush,
    output logic             o_halted,
    output logic [1:0]       o_state,
    output logic [31:0]      o_stall_cycles,
    output logic [31:0]      o_flush_count
);

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_STALL  = 2'b01;
    localparam logic [1:0] ST_DRAIN  = 2'b10;
    localparam logic [1:0] ST_HALTED = 2'b11;

    logic [1:0] r_state;
    logic [3:0] r_cnt;

    logic w_match;
    logic w_hazard;
    logic w_two_cycle;

    // Operand match against the EX destination; r0 never creates a hazard.
    assign w_match = (i_ex_dst != '0) &&
                     ((i_ex_dst == i_id_rs) || (i_id_uses_rt && (i_ex_dst == i_id_rt)));

    // Any of the three hazard classes; only branch-after-load needs two bubbles.
    assign w_hazard    = w_match && (i_ex_mem_read || (i_id_branch && i_ex_reg_write));
    assign w_two_cycle = w_match && i_ex_mem_read && i_id_branch;

    // Combinational control outputs: they must act in the detecting cycle.
    always_comb begin
        o_risk        = 1'b0;
        o_pc_write    = 1'b0;
        o_if_id_write = 1'b0;
        o_if_id_flush = 1'b0;
        o_halted      = 1'b0;
        if (i_reset) begin
            o_halted = 1'b0;
        end else if (!i_enable) begin
            o_halted = (r_state == ST_HALTED);
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_hazard) begin
                        o_risk = 1'b1;
                    end else begin
                        o_pc_write    = 1'b1;
                        o_if_id_write = 1'b1;
                        o_if_id_flush = i_id_taken;
                    end
                end
                ST_STALL:  o_risk = 1'b1;
                ST_DRAIN:  o_risk = 1'b1;
                default: begin
                    o_risk   = 1'b1;
                    o_halted = 1'b1;
                end
            endcase
        end
    end

    assign o_state = i_reset ? ST_RUN : r_state;

    // State machine and shared stall/drain counter; frozen while disabled.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else if (i_enable) begin
            case (r_state)
                ST_RUN: begin
                    if (w_hazard) begin
                        if (w_two_cycle) begin
                            r_state <= ST_STALL;
                            r_cnt   <= 4'd1;
                        end
                    end else if (i_id_halt) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= 4'(DRAIN_CYCLES);
                    end
                end
                ST_STALL: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= ST_RUN;
                end
                ST_DRAIN: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= ST_HALTED;
                end
                default: r_state <= ST_HALTED;
            endcase
        end
    end

`ifdef RISK_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    // Performance counters: bubbles from hazards (not drain) and IF/ID flushes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else if (i_enable) begin
            if (o_risk && ((r_state == ST_RUN) || (r_state == ST_STALL)))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (o_if_id_flush)
                r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign o_stall_cycles = i_reset ? 32'd0 : r_stall_cycles;
    assign o_flush_count  = i_reset ? 32'd0 : r_flush_count;
`else
    assign o_stall_cycles = 32'd0;
    assign o_flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_risk_sequencer.sv
// Scoreboard bench for risk_sequencer: a driver applies directed and random
// ID/EX contents, a behavioural model pushes the expected outputs into a
// queue, and a monitor on the falling edge pops and compares.
module tb_risk_sequencer;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [4:0]  id_rs, id_rt, ex_dst;
    logic        uses_rt, branch, taken, halt, ex_rw, ex_mr;
    logic        risk, pc_w, ifid_w, flush, halted;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;

    typedef struct packed {
        logic        risk;
        logic        pc_w;
        logic        ifid_w;
        logic        flush;
        logic        halted;
        logic [1:0]  state;
        logic [31:0] stalls;
        logic [31:0] flushes;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    bit   done    = 0;

    // Model state: plain counts of what is still owed to the pipeline.
    int          bubbles_left = 0;
    int          drain_left   = 0;
    bit          is_halted    = 0;
    logic [31:0] m_stalls     = 0;
    logic [31:0] m_flushes    = 0;

    always #5 clk = ~clk;

    risk_sequencer #(.DRAIN_CYCLES(DC), .REG_W(5)) dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(uses_rt),
        .i_id_branch(branch), .i_id_taken(taken), .i_id_halt(halt),
        .i_ex_reg_write(ex_rw), .i_ex_mem_read(ex_mr), .i_ex_dst(ex_dst),
        .o_risk(risk), .o_pc_write(pc_w), .o_if_id_write(ifid_w),
        .o_if_id_flush(flush), .o_halted(halted), .o_state(state),
        .o_stall_cycles(stall_cnt), .o_flush_count(flush_cnt)
    );

    // Expected outputs for the inputs currently applied, then advance the model.
    task automatic predict();
        exp_t e;
        bit   hit, haz;
        e = '0;
        e.state = is_halted ? 2'b11 : (drain_left > 0) ? 2'b10 :
                  (bubbles_left > 0) ? 2'b01 : 2'b00;
`ifdef RISK_PERF_CNT_EN
        e.stalls  = m_stalls;
        e.flushes = m_flushes;
`endif
        if (reset) begin
            e = '0;
            bubbles_left = 0; drain_left = 0; is_halted = 0;
            m_stalls = 0; m_flushes = 0;
        end else if (!enable) begin
            e.halted = is_halted;
        end else if (is_halted) begin
            e.risk = 1; e.halted = 1;
        end else if (drain_left > 0) begin
            e.risk = 1;
            drain_left--;
            if (drain_left == 0) is_halted = 1;
        end else if (bubbles_left > 0) begin
            e.risk = 1;
            bubbles_left--;
            m_stalls++;
        end else begin
            hit = (ex_dst != 0) && (ex_dst == id_rs || (uses_rt && ex_dst == id_rt));
            haz = hit && (ex_mr || (branch && ex_rw));
            if (haz) begin
                e.risk = 1;
                m_stalls++;
                if (branch && ex_mr) bubbles_left = 1;
            end else begin
                e.pc_w = 1; e.ifid_w = 1; e.flush = taken;
                if (taken) m_flushes++;
                if (halt) drain_left = DC;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic apply(input bit rst, input bit en, input logic [4:0] rs,
                         input logic [4:0] rt, input bit urt, input bit br,
                         input bit tk, input bit hl, input bit rw, input bit mr,
                         input logic [4:0] dst);
        @(posedge clk);
        #1;
        reset = rst; enable = en; id_rs = rs; id_rt = rt; uses_rt = urt;
        branch = br; taken = tk; halt = hl; ex_rw = rw; ex_mr = mr; ex_dst = dst;
        predict();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 5'd0);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    always @(negedge clk) begin
        exp_t got, want;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = '{risk, pc_w, ifid_w, flush, halted, state, stall_cnt, flush_cnt};
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL vec%0d: got risk=%b pc=%b ifid=%b fl=%b halt=%b st=%b sc=%0d fc=%0d, want risk=%b pc=%b ifid=%b fl=%b halt=%b st=%b sc=%0d fc=%0d",
                         vectors, got.risk, got.pc_w, got.ifid_w, got.flush, got.halted,
                         got.state, got.stalls, got.flushes, want.risk, want.pc_w,
                         want.ifid_w, want.flush, want.halted, want.state,
                         want.stalls, want.flushes);
            end
        end
    end

    initial begin
        reset = 1; enable = 1; id_rs = 0; id_rt = 0; uses_rt = 0; branch = 0;
        taken = 0; halt = 0; ex_rw = 0; ex_mr = 0; ex_dst = 0;
        // reset cycle, then first RUN cycle
        apply(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0);
        idle(1);
        // load-use: one bubble
        apply(0, 1, 8, 3, 0, 0, 0, 0, 1, 1, 5'd8);
        idle(2);
        // branch after load via rt: two bubbles
        apply(0, 1, 4, 9, 1, 1, 0, 0, 1, 1, 5'd9);
        apply(0, 1, 4, 9, 1, 1, 0, 0, 1, 1, 5'd9);
        idle(1);
        // branch after ALU write: one bubble
        apply(0, 1, 6, 0, 0, 1, 0, 0, 1, 0, 5'd6);
        // zero register never matches
        apply(0, 1, 0, 0, 1, 0, 0, 0, 1, 1, 5'd0);
        // taken branch without hazard, then taken plus load-use
        apply(0, 1, 1, 2, 0, 1, 1, 0, 0, 0, 5'd7);
        apply(0, 1, 7, 2, 0, 0, 1, 0, 1, 1, 5'd7);
        // disable in the middle of a two-bubble stall
        apply(0, 1, 9, 0, 0, 1, 0, 0, 1, 1, 5'd9);
        apply(0, 0, 9, 0, 0, 1, 0, 0, 1, 1, 5'd9);
        apply(0, 0, 1, 2, 0, 0, 1, 0, 0, 0, 5'd0);
        apply(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 5'd0);
        idle(1);
        // HALT: full drain then HALTED, with a disabled cycle while halted
        apply(0, 1, 1, 2, 0, 0, 0, 1, 0, 0, 5'd0);
        idle(DC + 2);
        apply(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 5'd0);
        apply(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0);
        // reset in the middle of DRAIN
        apply(0, 1, 1, 2, 0, 0, 0, 1, 0, 0, 5'd0);
        idle(2);
        apply(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0);
        idle(2);
        // random traffic over a small register window to provoke matches
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 29) == 0), 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 3)));
        end
        done = 1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (done);
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL timeout: bench did not complete, want completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
